// File: rtl/mr1_instr_mem.sv
// Instruction memory slave for the MR1 fetch port: fixed-latency, in-order responses
// from an internal word array that is filled through a separate program-load port.
module mr1_instr_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_req_valid,
  output logic             instr_req_ready,
  input  logic [31:0]      instr_req_addr,
  output logic             instr_rsp_valid,
  output logic [31:0]      instr_rsp_data,
  input  logic             mem_stall,
  input  logic             load_valid,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_data,
  output logic [CNT_W-1:0] stat_req_cnt
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]               r_mem [MEM_WORDS];
  logic                      r_init_done;
  logic [LATENCY-1:0]        r_vld_pipe;
  logic [LATENCY-1:0][31:0]  r_dat_pipe;
  logic [CNT_W-1:0]          r_cnt;

  logic [AW-1:0] w_req_idx;
  logic [AW-1:0] w_load_idx;
  logic          w_accept;
  logic          w_unused;

  assign w_req_idx       = instr_req_addr[2 +: AW];
  assign w_load_idx      = load_addr[2 +: AW];
  assign instr_req_ready = r_init_done & ~mem_stall;
  assign w_accept        = instr_req_valid & instr_req_ready;
  assign w_unused        = ^{instr_req_addr[31:AW+2], instr_req_addr[1:0],
                             load_addr[31:AW+2], load_addr[1:0]};

  // Program storage survives reset so a bench can load it while reset is held.
  always_ff @(posedge clk) begin
    if (load_valid) r_mem[w_load_idx] <= load_data;
  end

  // Data registers only advance behind a valid bit, so the output holds its last
  // response between fetches. Same-edge load/fetch naturally returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init_done <= 1'b0;
      r_vld_pipe  <= '0;
      r_dat_pipe  <= '0;
      r_cnt       <= '0;
    end else begin
      r_init_done   <= 1'b1;
      r_vld_pipe[0] <= w_accept;
      if (w_accept) begin
        r_dat_pipe[0] <= r_mem[w_req_idx];
        r_cnt         <= r_cnt + CNT_W'(1);
      end
      for (int k = 1; k < LATENCY; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
      end
    end
  end

  assign instr_rsp_valid = r_vld_pipe[LATENCY-1];
  assign instr_rsp_data  = r_dat_pipe[LATENCY-1];
  assign stat_req_cnt    = r_cnt;
endmodule

// File: tb/tb_mr1_instr_mem.sv
// Directed bench: a LATENCY=1 instance and a LATENCY=3 / CNT_W=4 instance share inputs.
module tb_mr1_instr_mem;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid;
  logic [31:0] addr;
  logic        stall;
  logic        lv;
  logic [31:0] la, ld;
  logic        rdy1, rv1, rdy3, rv3;
  logic [31:0] rd1, rd3;
  logic [31:0] cnt1;
  logic [3:0]  cnt3;

  int total = 0;
  int bad   = 0;
  int acc   = 0;
  logic [31:0] m [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  mr1_instr_mem #(.MEM_WORDS(1024), .LATENCY(1), .CNT_W(32)) u1 (
    .clk(clk), .reset_n(reset_n), .instr_req_valid(valid), .instr_req_ready(rdy1),
    .instr_req_addr(addr), .instr_rsp_valid(rv1), .instr_rsp_data(rd1),
    .mem_stall(stall), .load_valid(lv), .load_addr(la), .load_data(ld),
    .stat_req_cnt(cnt1));

  mr1_instr_mem #(.MEM_WORDS(1024), .LATENCY(3), .CNT_W(4)) u3 (
    .clk(clk), .reset_n(reset_n), .instr_req_valid(valid), .instr_req_ready(rdy3),
    .instr_req_addr(addr), .instr_rsp_valid(rv3), .instr_rsp_data(rd3),
    .mem_stall(stall), .load_valid(lv), .load_addr(la), .load_data(ld),
    .stat_req_cnt(cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = 32'h1000_0000 + 32'(i);
    m[4] = 32'h0020_8133;
    m[8] = 32'h0000_0013;
    tbl[0] = '{32'h0000_0010, 32'h0020_8133};
    tbl[1] = '{32'h0000_0000, 32'h1000_0000};
    tbl[2] = '{32'h0000_003C, 32'h1000_000F};
    tbl[3] = '{32'h0000_1000, 32'h1000_0000};
    tbl[4] = '{32'h0000_1007, 32'h1000_0001};

    // Reset held with valid high; program loaded while in reset.
    reset_n = 1'b0; valid = 1'b1; addr = '0; stall = 1'b0;
    lv = 1'b0; la = '0; ld = '0;
    for (int i = 0; i < 16; i++) begin
      lv = 1'b1; la = 32'(i * 4); ld = m[i];
      tick();
    end
    lv = 1'b0;
    check("rst_ready1", 32'(rdy1), 0);
    check("rst_ready3", 32'(rdy3), 0);
    check("rst_rvalid1", 32'(rv1), 0);
    check("rst_rdata3", rd3, 0);
    check("rst_cnt1", cnt1, 0);
    valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(rdy1), 0);
    tick();
    check("ready_after_edge", 32'(rdy1), 1);

    // Single fetches on the LATENCY=1 instance, including aliasing and ignored low bits.
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; addr = tbl[i].addr;
      tick();
      valid = 1'b0; acc++;
      check("vec_rvalid", 32'(rv1), 1);
      check("vec_rdata", rd1, tbl[i].exp);
      check("vec_cnt", cnt1, 32'(acc));
      tick();
      check("vec_rvalid_off", 32'(rv1), 0);
      check("vec_rdata_hold", rd1, tbl[i].exp);
      tick(); tick();
    end

    // Back-to-back fetches: LATENCY=3 responses appear in order after two more edges.
    for (int c = 0; c < 9; c++) begin
      valid = (c < 4); addr = 32'(c * 4);
      tick();
      if (c < 4) acc++;
      check("l3_rvalid", 32'(rv3), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) check("l3_rdata", rd3, m[c-2]);
      check("l1_rvalid", 32'(rv1), 32'(c < 4));
    end
    valid = 1'b0;
    check("b2b_cnt", cnt1, 32'(acc));

    // Stall for two cycles with two requests in flight.
    for (int c = 0; c < 6; c++) begin
      valid = (c < 4); addr = 32'h10 + 32'(c * 4);
      stall = (c == 2 || c == 3);
      #1;
      check("stall_ready", 32'(rdy3), 32'(!(c == 2 || c == 3)));
      if (valid && !stall) acc++;
      tick();
      check("stall_rvalid", 32'(rv3), 32'(c == 2 || c == 3));
      if (c == 2 || c == 3) check("stall_rdata", rd3, m[4 + c - 2]);
      check("stall_cnt", cnt1, 32'(acc));
    end
    stall = 1'b0; valid = 1'b0;

    // Load and fetch of the same word on the same edge returns the old word.
    valid = 1'b1; addr = 32'h20; lv = 1'b1; la = 32'h20; ld = 32'hDEAD_BEEF;
    tick();
    lv = 1'b0; valid = 1'b0; acc++;
    check("rbw_old", rd1, 32'h0000_0013);
    valid = 1'b1;
    tick();
    valid = 1'b0; acc++;
    check("rbw_new", rd1, 32'hDEAD_BEEF);
    check("rbw_cnt", cnt1, 32'(acc));
    tick(); tick(); tick();

    // Reset asserted with two requests in the LATENCY=3 pipeline.
    valid = 1'b1; addr = 32'h0;
    tick();
    addr = 32'h4;
    tick();
    valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_rvalid3", 32'(rv3), 0);
    check("midrst_cnt1", cnt1, 0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_rst_rvalid3", 32'(rv3), 0);
      check("post_rst_rvalid1", 32'(rv1), 0);
    end

    // Sixteen accepts wrap the 4-bit counter back to zero.
    valid = 1'b1; addr = 32'h0;
    tick();
    check("new_acc_rvalid", 32'(rv1), 1);
    check("new_acc_rdata", rd1, m[0]);
    for (int c = 0; c < 15; c++) tick();
    valid = 1'b0;
    check("wrap_cnt1", cnt1, 32'd16);
    check("wrap_cnt3", 32'(cnt3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
